// File: rtl/ycconfig_loader_if.sv
// Cell-code handshake between a code source (master) and the configuration loader (slave).
// A code transfers on a confclk edge where code_valid and code_ready are both 1; the source holds code/code_valid stable until then.
interface ycconfig_loader_if #(
  parameter int CBITS = 3
);
  logic             code_valid;
  logic [CBITS-1:0] code;
  logic             code_ready;

  modport master (
    output code_valid,
    output code,
    input  code_ready
  );

  modport slave (
    input  code_valid,
    input  code,
    output code_ready
  );
endinterface

// File: rtl/ycconfig_loader.sv
// Serialises CBITS-wide cell codes MSB-first into the yellow-cell configuration chain and flags frame completion.
// Build option READBACK_EN adds capture of the codes displaced out of the chain tail.
module ycconfig_loader #(
  parameter int CBITS  = 3,
  parameter int NCELLS = 16
) (
  input  logic             confclk,
  input  logic             reset,
  input  logic             abort,
  ycconfig_loader_if.slave cif,
  output logic             cbitout,
  output logic             cen,
  output logic             frame_done,
  output logic             busy,
  input  logic             cbitret,
  output logic             rb_valid,
  output logic [CBITS-1:0] rb_code,
  output logic [1:0]       dbg_state
);

  localparam int BW = (CBITS  > 1) ? $clog2(CBITS)  : 1;
  localparam int CW = (NCELLS > 1) ? $clog2(NCELLS) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(CBITS - 1);
  localparam logic [CW-1:0] LAST_CELL = CW'(NCELLS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CBITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    cell_cnt_q, cell_cnt_d;
  logic             code_ready_q, code_ready_d;
  logic             cbitout_q, cbitout_d;
  logic             cen_q, cen_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             accept;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    cell_cnt_d = cell_cnt_q;
    accept     = cif.code_valid & code_ready_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d   = cif.code;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          if (cell_cnt_q == LAST_CELL) begin
            cell_cnt_d = '0;
            state_d    = S_DONE;
          end else begin
            cell_cnt_d = cell_cnt_q + CW'(1);
            // Next code reloads on the final-bit edge so the chain never idles mid-frame.
            if (accept) begin
              shreg_d = cif.code;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      shreg_d    = '0;
      bit_cnt_d  = '0;
      cell_cnt_d = '0;
    end

    // Outputs are registered from the next-state view so they are flop-clean.
    cen_d        = (state_d == S_SHIFT);
    cbitout_d    = cen_d & shreg_d[CBITS-1];
    frame_done_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    code_ready_d = (state_d == S_IDLE) ||
                   ((state_d == S_SHIFT) && (bit_cnt_d == LAST_BIT) && (cell_cnt_d != LAST_CELL));
  end

  always_ff @(posedge confclk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      cell_cnt_q   <= '0;
      code_ready_q <= 1'b1;
      cbitout_q    <= 1'b0;
      cen_q        <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      cell_cnt_q   <= cell_cnt_d;
      code_ready_q <= code_ready_d;
      cbitout_q    <= cbitout_d;
      cen_q        <= cen_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign cif.code_ready = code_ready_q;
  assign cbitout        = cbitout_q;
  assign cen            = cen_q;
  assign frame_done     = frame_done_q;
  assign busy           = busy_q;
  assign dbg_state      = state_q;

`ifdef READBACK_EN
  logic [CBITS-1:0] rb_shift_q, rb_shift_d;
  logic [CBITS-1:0] rb_code_q, rb_code_d;
  logic [BW-1:0]    rb_cnt_q, rb_cnt_d;
  logic             rb_valid_q, rb_valid_d;

  // The chain tail moves on exactly the edges where cen is high, so capture on those.
  always_comb begin
    rb_shift_d = rb_shift_q;
    rb_code_d  = rb_code_q;
    rb_cnt_d   = rb_cnt_q;
    rb_valid_d = 1'b0;
    if (cen_q) begin
      rb_shift_d = CBITS'({rb_shift_q, cbitret});
      if (rb_cnt_q == LAST_BIT) begin
        rb_cnt_d   = '0;
        rb_code_d  = rb_shift_d;
        rb_valid_d = 1'b1;
      end else begin
        rb_cnt_d = rb_cnt_q + BW'(1);
      end
    end
    if (abort) begin
      rb_shift_d = '0;
      rb_code_d  = rb_code_q;
      rb_cnt_d   = '0;
      rb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge confclk or posedge reset) begin
    if (reset) begin
      rb_shift_q <= '0;
      rb_code_q  <= '0;
      rb_cnt_q   <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_shift_q <= rb_shift_d;
      rb_code_q  <= rb_code_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_valid = rb_valid_q;
  assign rb_code  = rb_code_q;
`else
  logic unused_cbitret;
  assign unused_cbitret = cbitret;
  assign rb_valid       = 1'b0;
  assign rb_code        = '0;
`endif

endmodule
